// File: rtl/shift_add_multiplier_8bit_if.sv
// Start/busy/done handshake and operand/product bus of the shift-and-add multiplier.
// master drives the request side; slave is the multiplier.
interface shift_add_multiplier_8bit_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, in1, in2, input busy, done, product);
  modport slave  (input start, in1, in2, output busy, done, product);
endinterface

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential unsigned 8x8 -> 16 radix-2 shift-and-add multiplier around one ripple-carry adder.
// One multiplier bit retired per cycle; the 9-bit adder result is shifted back into {A,Q}.
module ripple_carry_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  logic [WIDTH:0] c;

  assign c[0] = c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = in1[i] ^ in2[i] ^ c[i];
    assign c[i+1]   = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
  end
  assign c_out = c[WIDTH];
endmodule

module shift_add_multiplier_8bit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  shift_add_multiplier_8bit_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_b, add_sum;
  logic               add_co;
  logic [2*WIDTH-1:0] p_next;

  assign add_b = q_q[0] ? mcand_q : '0;

  ripple_carry_adder_8bit #(.WIDTH(WIDTH)) u_rca (
    .in1   (a_q),
    .in2   (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // Carry lands in P[15]; the retired multiplier bit falls off the bottom.
  assign p_next = {add_co, add_sum, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    a_d       = a_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.in1;
          q_d     = bus.in2;
          a_d     = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        {a_d, q_d} = p_next;
        count_d    = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH-1)) begin
          product_d = p_next;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      a_q       <= '0;
      q_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      a_q       <= a_d;
      q_q       <= q_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier_8bit.sv
// Randomized bench for the shift-and-add multiplier; reference is plain a*b with fixed 8-cycle latency.
module tb_shift_add_multiplier_8bit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_add_multiplier_8bit_if bus ();

  shift_add_multiplier_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Present a request, let the next edge accept it, then scramble operands.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in1   = 8'($urandom);
    bus.in2   = 8'($urandom);
  endtask

  // Count edges from acceptance to done; optionally hammer start with junk while busy.
  task automatic wait_done(input string tag, input logic [15:0] exp, input bit noise);
    int lat = 0;
    bit busy_ok = 1'b1;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
      if (noise && lat < 7) begin
        bus.start = 1'b1;
        bus.in1   = 8'($urandom);
        bus.in2   = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_busy_run"}, 32'(busy_ok), 1);
    chk({tag, "_prod"}, 32'(bus.product), 32'(exp));
    chk({tag, "_busy_done"}, 32'(bus.busy), 0);
  endtask

  task automatic after_done(input string tag, input logic [15:0] exp);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, 32'(bus.done), 0);
    chk({tag, "_prod_hold"}, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    logic [7:0] a, b, c, d;
    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_prod", 32'(bus.product), 0);
    @(negedge clk);
    rst = 1'b0;

    launch(8'd13, 8'd11);
    chk("t2_busy_accept", 32'(bus.busy), 1);
    wait_done("t2", 16'h008F, 1'b0);
    after_done("t2", 16'h008F);

    launch(8'hFF, 8'hFF);
    wait_done("t3", 16'hFE01, 1'b0);
    after_done("t3", 16'hFE01);

    launch(8'h00, 8'hA5);
    wait_done("t4a", 16'h0000, 1'b0);
    after_done("t4a", 16'h0000);
    launch(8'hA5, 8'h00);
    wait_done("t4b", 16'h0000, 1'b0);
    after_done("t4b", 16'h0000);

    // Ignored starts during RUN
    launch(8'd77, 8'd201);
    wait_done("t5_ign", 16'(77 * 201), 1'b1);
    // Back-to-back: request in the done cycle
    launch(8'd99, 8'd37);
    chk("t5_b2b_done_low", 32'(bus.done), 0);
    chk("t5_b2b_busy_high", 32'(bus.busy), 1);
    wait_done("t5_b2b", 16'(99 * 37), 1'b0);
    after_done("t5_b2b", 16'(99 * 37));

    // Reset mid-RUN
    launch(8'd250, 8'd250);
    repeat (4) begin @(posedge clk); #1; end
    chk("t6_busy_mid", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_prod", 32'(bus.product), 0);
    chk("t6_rst_done", 32'(bus.done), 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_no_done", 32'(bus.done), 0);
    launch(8'd200, 8'd3);
    wait_done("t6_fresh", 16'h0258, 1'b0);
    after_done("t6_fresh", 16'h0258);

    // Randomized traffic, with random back-to-back chaining and start noise
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      launch(a, b);
      wait_done("rnd", 16'(a) * 16'(b), 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        c = 8'($urandom);
        d = 8'($urandom);
        launch(c, d);
        wait_done("rnd_b2b", 16'(c) * 16'(d), 1'b0);
        after_done("rnd_b2b", 16'(c) * 16'(d));
      end else begin
        after_done("rnd", 16'(a) * 16'(b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
